// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and MDU occupancy tracking.
// Optional saturating stall counter enabled by HAZ_STALL_CNT_EN.
module hazard_controller #(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic [REG_W-1:0] ID_EXE_rt,
    input  logic             ID_EXE_MemRead,
    input  logic             EXE_branch_taken,
    input  logic             ID_mdu_start,
    input  logic             ID_mdu_read,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EXE_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int LAT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    mdu_state_t        state, state_nxt;
    logic [LAT_W-1:0]  cnt, cnt_nxt;
    logic              load_use, mdu_haz, advance;

    assign mdu_busy = (state == BUSY);

    assign load_use = ID_EXE_MemRead && (ID_EXE_rt != '0) &&
                      ((ID_EXE_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EXE_rt == IF_ID_rt)));
    assign mdu_haz  = mdu_busy && (ID_mdu_start || ID_mdu_read);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EXE_bubble = 1'b0;
        advance       = 1'b0;

        // Branch outranks stalls: the stalled ID instruction is squashed anyway.
        if (!rst_n) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EXE_bubble = 1'b1;
        end else if (EXE_branch_taken) begin
            IF_ID_flush   = 1'b1;
            ID_EXE_bubble = 1'b1;
        end else if (load_use || mdu_haz) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EXE_bubble = 1'b1;
        end else begin
            advance = 1'b1;
        end

        case (state)
            IDLE: begin
                if (ID_mdu_start && advance) begin
                    state_nxt = BUSY;
                    cnt_nxt   = LAT_W'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!PC_write && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MDU_LAT=4); a second instance with CNT_W=2 checks counter saturation.
module tb_hazard_controller;

`ifdef HAZ_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] exe_rt;
        logic       memread;
        logic       branch;
        logic       mstart;
        logic       mread;
        logic       e_pc;
        logic       e_ifw;
        logic       e_flush;
        logic       e_bub;
        logic       e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  IF_ID_rs = '0, IF_ID_rt = '0, ID_EXE_rt = '0;
    logic        IF_ID_uses_rt = 1'b0, ID_EXE_MemRead = 1'b0, EXE_branch_taken = 1'b0;
    logic        ID_mdu_start = 1'b0, ID_mdu_read = 1'b0;
    logic        pc_a, ifw_a, flush_a, bub_a, busy_a;
    logic        pc_b, ifw_b, flush_b, bub_b, busy_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_W(5), .MDU_LAT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_uses_rt(IF_ID_uses_rt), .ID_EXE_rt(ID_EXE_rt), .ID_EXE_MemRead(ID_EXE_MemRead),
        .EXE_branch_taken(EXE_branch_taken), .ID_mdu_start(ID_mdu_start), .ID_mdu_read(ID_mdu_read),
        .PC_write(pc_a), .IF_ID_write(ifw_a), .IF_ID_flush(flush_a), .ID_EXE_bubble(bub_a),
        .mdu_busy(busy_a), .stall_count(cnt_a)
    );

    hazard_controller #(.REG_W(5), .MDU_LAT(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_uses_rt(IF_ID_uses_rt), .ID_EXE_rt(ID_EXE_rt), .ID_EXE_MemRead(ID_EXE_MemRead),
        .EXE_branch_taken(EXE_branch_taken), .ID_mdu_start(ID_mdu_start), .ID_mdu_read(ID_mdu_read),
        .PC_write(pc_b), .IF_ID_write(ifw_b), .IF_ID_flush(flush_b), .ID_EXE_bubble(bub_b),
        .mdu_busy(busy_b), .stall_count(cnt_b)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic e_pc, input logic e_ifw,
                           input logic e_flush, input logic e_bub, input logic e_busy);
        int e16;
        int e2;
        e16 = CNT_ON ? ((exp_cnt > 65535) ? 65535 : exp_cnt) : 0;
        e2  = CNT_ON ? ((exp_cnt > 3) ? 3 : exp_cnt) : 0;
        chk({name, ".PC_write"},      int'(pc_a),    int'(e_pc));
        chk({name, ".IF_ID_write"},   int'(ifw_a),   int'(e_ifw));
        chk({name, ".IF_ID_flush"},   int'(flush_a), int'(e_flush));
        chk({name, ".ID_EXE_bubble"}, int'(bub_a),   int'(e_bub));
        chk({name, ".mdu_busy"},      int'(busy_a),  int'(e_busy));
        chk({name, ".stall_count"},   int'(cnt_a),   e16);
        chk({name, ".b.PC_write"},    int'(pc_b),    int'(e_pc));
        chk({name, ".b.IF_ID_write"}, int'(ifw_b),   int'(e_ifw));
        chk({name, ".b.IF_ID_flush"}, int'(flush_b), int'(e_flush));
        chk({name, ".b.bubble"},      int'(bub_b),   int'(e_bub));
        chk({name, ".b.mdu_busy"},    int'(busy_b),  int'(e_busy));
        chk({name, ".b.stall_count"}, int'(cnt_b),   e2);
    endtask

    // Drive one ID/EXE cycle, check outputs mid-cycle, account for the counter update at the next edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        IF_ID_rs = v.rs; IF_ID_rt = v.rt; IF_ID_uses_rt = v.uses_rt;
        ID_EXE_rt = v.exe_rt; ID_EXE_MemRead = v.memread; EXE_branch_taken = v.branch;
        ID_mdu_start = v.mstart; ID_mdu_read = v.mread;
        #1;
        chk_all(name, v.e_pc, v.e_ifw, v.e_flush, v.e_bub, v.e_busy);
        if (!v.e_pc) exp_cnt++;
    endtask

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                input logic [4:0] exe_rt, input logic memread, input logic branch,
                                input logic mstart, input logic mread, input logic [4:0] exp_o);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.exe_rt = exe_rt; v.memread = memread;
        v.branch = branch; v.mstart = mstart; v.mread = mread;
        {v.e_pc, v.e_ifw, v.e_flush, v.e_bub, v.e_busy} = exp_o;
        return v;
    endfunction

    localparam logic [4:0] ADV   = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] FLUSH = 5'b11110;

    vec_t tbl[12];

    initial begin
        //              rs rt u  ert mr br ms rd  expected
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, ADV);
        tbl[1]  = mk(8, 0, 0, 8, 1, 0, 0, 0, STALL);
        tbl[2]  = mk(8, 0, 0, 8, 0, 0, 0, 0, ADV);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, ADV);
        tbl[4]  = mk(3, 9, 0, 9, 1, 0, 0, 0, ADV);
        tbl[5]  = mk(3, 9, 1, 9, 1, 0, 0, 0, STALL);
        tbl[6]  = mk(8, 8, 1, 8, 1, 1, 0, 0, FLUSH);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, FLUSH);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, ADV);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, ADV);
        tbl[10] = mk(5, 5, 1, 5, 1, 0, 0, 0, STALL);
        tbl[11] = mk(4, 0, 0, 5, 1, 0, 0, 0, ADV);

        #12;
        chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;

        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // mult accepted, then mfhi stalls for exactly MDU_LAT cycles
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, ADV),   "mdu_start");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, STALL | 5'b00001), "mfhi_b1");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, STALL | 5'b00001), "mfhi_b2");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, STALL | 5'b00001), "mfhi_b3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, STALL | 5'b00001), "mfhi_b4");
        // first idle cycle: a new mult proceeds and re-enters BUSY
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, ADV),   "mult_reissue");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, ADV | 5'b00001),   "busy_again");
        apply(mk(0, 0, 0, 0, 0, 1, 1, 0, FLUSH | 5'b00001), "branch_busy");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, ADV | 5'b00001),   "busy_cnt1");
        apply(mk(8, 0, 0, 8, 1, 0, 0, 1, STALL | 5'b00001), "lu_and_mdu");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, ADV),   "mfhi_after");

        // reset during BUSY cycle 2, between clock edges
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, ADV),   "mdu_start2");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, ADV | 5'b00001), "busy_c1");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, ADV | 5'b00001), "busy_c2");
        #1;
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk_all("mid_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, ADV),   "mfhi_post_rst");

        // 3 load-use stalls + 4 MDU stalls after reset
        apply(mk(8, 0, 0, 8, 1, 0, 0, 0, STALL), "lu1");
        apply(mk(7, 7, 1, 7, 1, 0, 0, 0, STALL), "lu2");
        apply(mk(6, 0, 0, 6, 1, 0, 0, 0, STALL), "lu3");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, ADV),   "mdu_start3");
        for (int i = 0; i < 4; i++)
            apply(mk(0, 0, 0, 0, 0, 0, 1, 0, STALL | 5'b00001), $sformatf("mult_wait%0d", i));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, ADV),   "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. Sits beside the forwarding unit and decides each cycle whether IF/ID advance, stall or flush.
- Covers three cases that forwarding cannot resolve:
  - load-use data hazards;
  - taken-branch flushes;
  - structural and data hazards on the multi-cycle multiply/divide unit (MDU) and its HI/LO registers.
- Tracks MDU occupancy with an internal countdown state machine.

Parameters:
- REG_W, 5, register-specifier width.
- MDU_LAT, 32, cycles the MDU stays busy after accepting an operation (minimum 2).
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_rs  in  REG_W  rs of the instruction in ID.
- IF_ID_rt  in  REG_W  rt of the instruction in ID.
- IF_ID_uses_rt  in  1  ID instruction reads rt as a source.
- ID_EXE_rt  in  REG_W  destination rt of the instruction in EXE.
- ID_EXE_MemRead  in  1  EXE instruction is a load.
- EXE_branch_taken  in  1  branch resolved taken in EXE this cycle.
- ID_mdu_start  in  1  ID instruction is mult/multu/div/divu.
- ID_mdu_read  in  1  ID instruction is mfhi/mflo.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  clear IF/ID to a NOP.
- ID_EXE_bubble  out  1  insert a NOP into ID/EXE.
- mdu_busy  out  1  MDU operation in flight.
- stall_count  out  CNT_W  stalled-cycle counter (optional feature).

Behaviour:
- Outputs are combinational from the registered state plus the current inputs, so a stall takes effect in the same cycle the hazard is present.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, mdu_busy=0.
  - Outputs forced to PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EXE_bubble=1, stall_count=0.
  - Reset in the middle of an MDU operation abandons it; the counter clears.
- Hazard terms:
  - load_use = ID_EXE_MemRead && ID_EXE_rt!=0 && (ID_EXE_rt==IF_ID_rs || (IF_ID_uses_rt && ID_EXE_rt==IF_ID_rt)).
  - mdu_haz = mdu_busy && (ID_mdu_start || ID_mdu_read).
- Priority per cycle, highest first:
  1. EXE_branch_taken: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EXE_bubble=1. Any stall condition is ignored because the ID instruction is squashed.
  2. load_use: PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EXE_bubble=1. Lasts exactly one cycle, since the load then moves to MEM.
  3. mdu_haz: same stall pattern as load_use; repeats every cycle until mdu_busy falls.
  4. Otherwise: PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EXE_bubble=0.
- MDU state machine (IDLE, BUSY):
  - IDLE to BUSY: at a clock edge where ID_mdu_start=1 and the case-4 (advance) condition holds. The counter loads MDU_LAT-1.
  - An ID_mdu_start that is flushed or stalled is NOT accepted.
  - BUSY: mdu_busy=1; the counter decrements each cycle. When counter==0, return to IDLE at the next edge, so mdu_busy is high for exactly MDU_LAT cycles.
  - In the first IDLE cycle after BUSY, a waiting mfhi/mflo or mult proceeds. A new mult accepted in that cycle re-enters BUSY.
  - A taken branch while BUSY does not abort the MDU; the counter keeps running.
- Simultaneous load_use and mdu_haz: one stall cycle; mdu_haz alone then continues the stall as needed.
- Register $zero (specifier 0) never causes a load-use stall.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- Defined: stall_count increments on every cycle with rst_n=1 and PC_write=0. It saturates at all-ones and never wraps. It clears only on reset.
- Not defined: stall_count is tied to 0 and no counter flops exist. The port list is unchanged.

Test Plan:
- Load-use: ID_EXE_MemRead=1, ID_EXE_rt=8, IF_ID_rs=8 -> one cycle with PC_write=0, IF_ID_write=0, ID_EXE_bubble=1. Next cycle MemRead=0 -> PC_write=1. Repeat with ID_EXE_rt=0 -> no stall.
- rt use gating: ID_EXE_rt=9, IF_ID_rt=9, IF_ID_uses_rt=0 -> no stall. With IF_ID_uses_rt=1 -> stall.
- MDU_LAT=4: pulse ID_mdu_start=1 for one cycle -> mdu_busy high exactly 4 cycles. An mfhi in ID during that window stalls every cycle and advances on the first cycle mdu_busy=0.
- Branch priority: load_use=1 and EXE_branch_taken=1 together -> IF_ID_flush=1, ID_EXE_bubble=1, PC_write=1. Branch with mult in ID -> mult not accepted, mdu_busy stays 0.
- Reset mid-MDU: assert rst_n=0 in BUSY cycle 2 without a clock edge -> mdu_busy=0 and PC_write=0 immediately. After release, state is IDLE and an mfhi advances with no stall.
- HAZ_STALL_CNT_EN defined: 3 load-use stalls + 4 MDU stall cycles -> stall_count=7. With CNT_W=2, stall_count saturates at 3.
